// File: rtl/uctl_fifo_multi_ch_pkg.sv
// Shared types for the multi-channel FIFO: per-channel request bundle and count-width helper.
package uctl_fifo_multi_ch_pkg;

  // Decoded per-channel strobes handed from the top-level accept logic to each channel controller.
  typedef struct packed {
    logic flush;
    logic wr_acc;
    logic rd_acc;
    logic ovf_set;
    logic unf_set;
  } ch_req_t;

  function automatic int cnt_w(input int addrsize);
    return addrsize + 1;
  endfunction

endpackage

// File: rtl/uctl_fifo_ch_ctrl.sv
// One channel of the multi-channel FIFO: pointers, occupancy count, status flags and sticky errors.
module uctl_fifo_ch_ctrl
  import uctl_fifo_multi_ch_pkg::*;
#(
  parameter int FIFO_ADDRSIZE = 4,
  parameter int NEAR_FULL_TH  = 2,
  localparam int CW           = cnt_w(FIFO_ADDRSIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sw_rst,
  input  logic                     err_clr,
  input  ch_req_t                  i_req,
  output logic [FIFO_ADDRSIZE-1:0] o_wr_ptr,
  output logic [FIFO_ADDRSIZE-1:0] o_rd_ptr,
  output logic [CW-1:0]            o_cnt,
  output logic [CW-1:0]            o_free,
  output logic                     o_full,
  output logic                     o_nearly_full,
  output logic                     o_empty,
  output logic                     o_ovf,
  output logic                     o_unf
);

  localparam logic [CW-1:0] DEPTH_C = CW'(2**FIFO_ADDRSIZE);
  localparam logic [CW-1:0] NF_LVL  = CW'(2**FIFO_ADDRSIZE - NEAR_FULL_TH);

  logic [FIFO_ADDRSIZE-1:0] r_wr_ptr;
  logic [FIFO_ADDRSIZE-1:0] r_rd_ptr;
  logic [CW-1:0]            r_cnt;
  logic                     r_ovf;
  logic                     r_unf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (sw_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      // A new error in the same cycle as the clear must survive.
      r_ovf <= (r_ovf & ~err_clr) | i_req.ovf_set;
      r_unf <= (r_unf & ~err_clr) | i_req.unf_set;
      if (i_req.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (i_req.wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (i_req.rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
        if (i_req.wr_acc && !i_req.rd_acc)      r_cnt <= r_cnt + 1'b1;
        else if (!i_req.wr_acc && i_req.rd_acc) r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_wr_ptr      = r_wr_ptr;
  assign o_rd_ptr      = r_rd_ptr;
  assign o_cnt         = r_cnt;
  assign o_free        = DEPTH_C - r_cnt;
  assign o_full        = (r_cnt == DEPTH_C);
  assign o_nearly_full = (r_cnt >= NF_LVL);
  assign o_empty       = (r_cnt == '0);
  assign o_ovf         = r_ovf;
  assign o_unf         = r_unf;

endmodule

// File: rtl/uctl_fifo_multi_ch.sv
// Multi-channel single-clock FIFO: NUM_CH circular queues in one shared memory, registered read port
// with valid/channel tag, per-channel flush and sticky overflow/underflow errors.
module uctl_fifo_multi_ch
  import uctl_fifo_multi_ch_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int FIFO_ADDRSIZE = 4,
  parameter int FIFO_DATASIZE = 32,
  parameter int NEAR_FULL_TH  = 2,
  localparam int CH_W         = $clog2(NUM_CH),
  localparam int CW           = cnt_w(FIFO_ADDRSIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sw_rst,
  input  logic                     wrEn,
  input  logic [CH_W-1:0]          wrCh,
  input  logic [FIFO_DATASIZE-1:0] dataIn,
  input  logic                     rdEn,
  input  logic [CH_W-1:0]          rdCh,
  output logic [FIFO_DATASIZE-1:0] dataOut,
  output logic                     dataOutVld,
  output logic [CH_W-1:0]          dataOutCh,
  input  logic [NUM_CH-1:0]        flush,
  input  logic                     errClr,
  output logic [NUM_CH-1:0]        full,
  output logic [NUM_CH-1:0]        nearly_full,
  output logic [NUM_CH-1:0]        empty,
  output logic [NUM_CH*CW-1:0]     numOfData,
  output logic [NUM_CH*CW-1:0]     numOfFreeLocs,
  output logic [NUM_CH-1:0]        ovfErr,
  output logic [NUM_CH-1:0]        unfErr
);

  localparam int DEPTH = 2**FIFO_ADDRSIZE;

  logic [FIFO_DATASIZE-1:0] r_mem [NUM_CH*DEPTH];
  logic [FIFO_DATASIZE-1:0] r_dout;
  logic                     r_vld;
  logic [CH_W-1:0]          r_dch;

  logic [FIFO_ADDRSIZE-1:0] w_wr_ptr [NUM_CH];
  logic [FIFO_ADDRSIZE-1:0] w_rd_ptr [NUM_CH];
  ch_req_t                  w_req    [NUM_CH];

  logic w_rd_acc;
  logic w_same_rd;
  logic w_wr_acc;
  logic w_wr_rej;
  logic w_rd_rej;

  // A full channel still takes a write when the same cycle's read frees a slot on it.
  assign w_rd_acc  = rdEn & ~empty[rdCh] & ~flush[rdCh] & ~sw_rst;
  assign w_same_rd = w_rd_acc & (rdCh == wrCh);
  assign w_wr_acc  = wrEn & ~flush[wrCh] & (~full[wrCh] | w_same_rd) & ~sw_rst;
  assign w_wr_rej  = wrEn & ~flush[wrCh] & ~w_wr_acc;
  assign w_rd_rej  = rdEn & ~flush[rdCh] & empty[rdCh];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_req[c] = '{flush:   flush[c],
                        wr_acc:  w_wr_acc & (wrCh == CH_W'(c)),
                        rd_acc:  w_rd_acc & (rdCh == CH_W'(c)),
                        ovf_set: w_wr_rej & (wrCh == CH_W'(c)),
                        unf_set: w_rd_rej & (rdCh == CH_W'(c))};

    uctl_fifo_ch_ctrl #(
      .FIFO_ADDRSIZE(FIFO_ADDRSIZE),
      .NEAR_FULL_TH (NEAR_FULL_TH)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .sw_rst       (sw_rst),
      .err_clr      (errClr),
      .i_req        (w_req[c]),
      .o_wr_ptr     (w_wr_ptr[c]),
      .o_rd_ptr     (w_rd_ptr[c]),
      .o_cnt        (numOfData[c*CW +: CW]),
      .o_free       (numOfFreeLocs[c*CW +: CW]),
      .o_full       (full[c]),
      .o_nearly_full(nearly_full[c]),
      .o_empty      (empty[c]),
      .o_ovf        (ovfErr[c]),
      .o_unf        (unfErr[c])
    );
  end

  // Storage is deliberately left out of reset; the channel is addressed by the upper index bits.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[{wrCh, w_wr_ptr[wrCh]}] <= dataIn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
      r_vld  <= 1'b0;
      r_dch  <= '0;
    end else if (sw_rst) begin
      r_dout <= '0;
      r_vld  <= 1'b0;
      r_dch  <= '0;
    end else if (w_rd_acc) begin
      r_dout <= r_mem[{rdCh, w_rd_ptr[rdCh]}];
      r_vld  <= 1'b1;
      r_dch  <= rdCh;
    end else begin
      r_vld  <= 1'b0;
    end
  end

  assign dataOut    = r_dout;
  assign dataOutVld = r_vld;
  assign dataOutCh  = r_dch;

endmodule

// File: tb/tb_uctl_fifo_multi_ch.sv
// Self-checking bench for uctl_fifo_multi_ch: queue-based reference model with read scoreboard,
// a vector table for error/pass-through cases, and directed flush/reset sequences.
module tb_uctl_fifo_multi_ch;

  localparam int NUM_CH = 4;
  localparam int A      = 4;
  localparam int D      = 32;
  localparam int TH     = 2;
  localparam int DEPTH  = 16;
  localparam int CW     = 5;

  logic          clk = 1'b0;
  logic          rst_n, sw_rst, wrEn, rdEn, errClr, dataOutVld;
  logic [1:0]    wrCh, rdCh, dataOutCh;
  logic [D-1:0]  dataIn, dataOut;
  logic [3:0]    flush, full, nearly_full, empty, ovfErr, unfErr;
  logic [19:0]   numOfData, numOfFreeLocs;

  always #5 clk = ~clk;

  uctl_fifo_multi_ch #(
    .NUM_CH(NUM_CH), .FIFO_ADDRSIZE(A), .FIFO_DATASIZE(D), .NEAR_FULL_TH(TH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .wrEn(wrEn), .wrCh(wrCh), .dataIn(dataIn),
    .rdEn(rdEn), .rdCh(rdCh), .dataOut(dataOut), .dataOutVld(dataOutVld), .dataOutCh(dataOutCh),
    .flush(flush), .errClr(errClr), .full(full), .nearly_full(nearly_full), .empty(empty),
    .numOfData(numOfData), .numOfFreeLocs(numOfFreeLocs), .ovfErr(ovfErr), .unfErr(unfErr)
  );

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] data;
  } rd_t;

  typedef struct {
    logic        wr;
    logic [1:0]  wch;
    logic [31:0] din;
    logic        rd;
    logic [1:0]  rch;
    logic [3:0]  fl;
    logic        ec;
    logic        exp_vld;
    logic [31:0] exp_dout;
    logic [1:0]  chk_ch;
    logic [4:0]  exp_cnt;
    logic [3:0]  exp_ovf;
    logic [3:0]  exp_unf;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mq [NUM_CH][$];
  rd_t         exp_q [$];
  logic [3:0]  m_ovf, m_unf;
  logic [31:0] m_dout;
  logic [1:0]  m_dch;
  logic        m_vld;
  vec_t        tv [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    exp_q.delete();
    m_ovf = '0; m_unf = '0; m_dout = '0; m_dch = '0; m_vld = 1'b0;
  endtask

  task automatic set_idle();
    wrEn = 1'b0; wrCh = '0; dataIn = '0; rdEn = 1'b0; rdCh = '0;
    flush = '0; errClr = 1'b0; sw_rst = 1'b0;
  endtask

  task automatic check_state();
    rd_t        e;
    logic [3:0]  x_empty, x_full, x_nf;
    logic [19:0] x_nd, x_fr;
    int          n;
    chk("vld", dataOutVld, m_vld);
    if (m_vld && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m_dout = e.data;
      m_dch  = e.ch;
    end
    chk("dout", dataOut, m_dout);
    chk("dch", dataOutCh, m_dch);
    for (int c = 0; c < NUM_CH; c++) begin
      n = mq[c].size();
      x_empty[c]       = (n == 0);
      x_full[c]        = (n == DEPTH);
      x_nf[c]          = (n >= DEPTH - TH);
      x_nd[c*CW +: CW] = 5'(n);
      x_fr[c*CW +: CW] = 5'(DEPTH - n);
    end
    chk("empty", empty, x_empty);
    chk("full", full, x_full);
    chk("nearly_full", nearly_full, x_nf);
    chk("numOfData", numOfData, x_nd);
    chk("numOfFreeLocs", numOfFreeLocs, x_fr);
    chk("ovfErr", ovfErr, m_ovf);
    chk("unfErr", unfErr, m_unf);
  endtask

  // Drives one cycle, advances the reference model and checks all outputs after the edge.
  task automatic step(input logic wr, input logic [1:0] wch, input logic [31:0] din,
                      input logic rd, input logic [1:0] rch, input logic [3:0] fl, input logic ec);
    logic rd_ok, wr_ok;
    rd_t  e;
    wrEn = wr; wrCh = wch; dataIn = din; rdEn = rd; rdCh = rch; flush = fl; errClr = ec;
    rd_ok = rd && !fl[rch] && (mq[rch].size() > 0);
    wr_ok = wr && !fl[wch] && ((mq[wch].size() < DEPTH) || (rd_ok && rch == wch));
    if (ec) begin m_ovf = '0; m_unf = '0; end
    if (wr && !fl[wch] && !wr_ok) m_ovf[wch] = 1'b1;
    if (rd && !fl[rch] && !rd_ok) m_unf[rch] = 1'b1;
    if (rd_ok) begin
      e.ch   = rch;
      e.data = mq[rch].pop_front();
      exp_q.push_back(e);
    end
    if (wr_ok) mq[wch].push_back(din);
    for (int c = 0; c < NUM_CH; c++) if (fl[c]) mq[c].delete();
    m_vld = rd_ok;
    @(posedge clk);
    #1;
    set_idle();
    check_state();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    model_reset();
    rst_n = 1'b0;
    #12;
    check_state();
    chk("rst_free_hand", numOfFreeLocs, {4{5'd16}});
    chk("rst_empty_hand", empty, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill ch1 to full
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 2'd1, 32'hA0 + i, 1'b0, 2'd0, 4'h0, 1'b0);
      chk("t1_nearly_full", nearly_full[1], (i + 1) >= 14);
    end
    chk("t1_full", full[1], 1'b1);
    chk("t1_free", numOfFreeLocs[1*CW +: CW], 5'd0);
    chk("t1_empty", empty, 4'b1101);

    // Drain ch1 back-to-back
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 2'd0, 32'h0, 1'b1, 2'd1, 4'h0, 1'b0);
      chk("t2_data", dataOut, 32'hA0 + i);
      chk("t2_ch", dataOutCh, 2'd1);
    end
    chk("t2_empty", empty[1], 1'b1);

    // Refill ch1 and ch2 for pass-through and error cases
    for (int i = 0; i < 16; i++) step(1'b1, 2'd1, 32'hB0 + i, 1'b0, 2'd0, 4'h0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 2'd2, 32'hC0 + i, 1'b0, 2'd0, 4'h0, 1'b0);

    tv[0] = '{1'b1, 2'd1, 32'h55, 1'b1, 2'd1, 4'h0, 1'b0, 1'b1, 32'hB0, 2'd1, 5'd16, 4'h0, 4'h0};
    tv[1] = '{1'b1, 2'd2, 32'h77, 1'b1, 2'd3, 4'h0, 1'b0, 1'b0, 32'hB0, 2'd2, 5'd16, 4'h4, 4'h8};
    tv[2] = '{1'b0, 2'd0, 32'h00, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 32'hB0, 2'd3, 5'd0,  4'h4, 4'h8};
    tv[3] = '{1'b0, 2'd0, 32'h00, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 32'hB0, 2'd2, 5'd16, 4'h0, 4'h0};
    tv[4] = '{1'b0, 2'd0, 32'h00, 1'b1, 2'd3, 4'h0, 1'b1, 1'b0, 32'hB0, 2'd3, 5'd0,  4'h0, 4'h8};
    tv[5] = '{1'b0, 2'd0, 32'h00, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 32'hB0, 2'd1, 5'd16, 4'h0, 4'h0};
    tv[6] = '{1'b1, 2'd1, 32'h66, 1'b1, 2'd2, 4'h0, 1'b0, 1'b1, 32'hC0, 2'd1, 5'd16, 4'h2, 4'h0};
    tv[7] = '{1'b0, 2'd0, 32'h00, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 32'hC0, 2'd2, 5'd15, 4'h0, 4'h0};
    for (int k = 0; k < 8; k++) begin
      step(tv[k].wr, tv[k].wch, tv[k].din, tv[k].rd, tv[k].rch, tv[k].fl, tv[k].ec);
      chk($sformatf("tv%0d_vld", k), dataOutVld, tv[k].exp_vld);
      chk($sformatf("tv%0d_dout", k), dataOut, tv[k].exp_dout);
      chk($sformatf("tv%0d_cnt", k), numOfData[tv[k].chk_ch*CW +: CW], tv[k].exp_cnt);
      chk($sformatf("tv%0d_ovf", k), ovfErr, tv[k].exp_ovf);
      chk($sformatf("tv%0d_unf", k), unfErr, tv[k].exp_unf);
    end

    // ch1 now holds B1..BF then the pass-through word
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 2'd0, 32'h0, 1'b1, 2'd1, 4'h0, 1'b0);
      chk("t3_data", dataOut, (i < 15) ? 32'hB1 + i : 32'h55);
    end
    for (int i = 0; i < 15; i++) step(1'b0, 2'd0, 32'h0, 1'b1, 2'd2, 4'h0, 1'b0);

    // Flush ch0 with a colliding write and read; ch1 must be untouched
    for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 32'hD0 + i, 1'b0, 2'd0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 32'hE0 + i, 1'b0, 2'd0, 4'h0, 1'b0);
    step(1'b1, 2'd0, 32'h99, 1'b1, 2'd0, 4'b0001, 1'b0);
    chk("t5_cnt0", numOfData[0 +: CW], 5'd0);
    chk("t5_vld", dataOutVld, 1'b0);
    chk("t5_err", {ovfErr, unfErr}, 8'h00);
    chk("t5_cnt1", numOfData[1*CW +: CW], 5'd3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd0, 32'h0, 1'b1, 2'd1, 4'h0, 1'b0);
      chk("t5_ch1_data", dataOut, 32'hE0 + i);
    end
    step(1'b0, 2'd0, 32'h0, 1'b1, 2'd0, 4'h0, 1'b0);
    chk("t5_unf0", unfErr, 4'b0001);
    step(1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 4'h0, 1'b1);

    // Soft reset overrides a simultaneous write and read
    for (int i = 0; i < 3; i++) step(1'b1, 2'd3, 32'hF0 + i, 1'b0, 2'd0, 4'h0, 1'b0);
    step(1'b0, 2'd0, 32'h0, 1'b1, 2'd3, 4'h0, 1'b0);
    sw_rst = 1'b1; wrEn = 1'b1; wrCh = 2'd3; dataIn = 32'h1234; rdEn = 1'b1; rdCh = 2'd3;
    @(posedge clk);
    #1;
    set_idle();
    model_reset();
    check_state();
    chk("swrst_dout", dataOut, 32'h0);

    // Random traffic on all channels
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), $urandom,
           $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
           ($urandom_range(0, 24) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0,
           $urandom_range(0, 30) == 0);
    end

    // Asynchronous reset in the middle of a burst
    wrEn = 1'b1; wrCh = 2'd0; dataIn = 32'hDEAD; rdEn = 1'b1; rdCh = 2'd0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state();
    chk("arst_free", numOfFreeLocs, {4{5'd16}});
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_state();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
